// File: rtl/credit_pkg.sv
// Shared definitions for the coin credit stage.
//   BAL_W / SUM_W : balance width and the wider intermediate used before clamping
//   COIN_A/B/C    : credit per coin button
//   BAL_MAX/MIN   : saturation limits of the balance
//   chg_state_t   : charge handshake FSM states
//   clamp_bal()   : saturate an intermediate sum into the balance range
package credit_pkg;

  localparam int BAL_W   = 12;
  localparam int SUM_W   = 14;

  localparam int COIN_A  = 1;
  localparam int COIN_B  = 5;
  localparam int COIN_C  = 10;

  localparam int BAL_MAX = 2047;
  localparam int BAL_MIN = -2048;

  typedef logic signed [BAL_W-1:0] bal_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    ACK,
    WAIT_LOW
  } chg_state_t;

  function automatic bal_t clamp_bal(input sum_t v);
    if (v > sum_t'(BAL_MAX)) begin
      return bal_t'(BAL_MAX);
    end else if (v < sum_t'(BAL_MIN)) begin
      return bal_t'(BAL_MIN);
    end else begin
      return bal_t'(v);
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce counter, rising-edge pulse.
//   clk   : system clock
//   rst   : asynchronous, active-low reset
//   raw   : raw asynchronous button, active-high
//   level : debounced button level
//   press : one-cycle pulse, high in the first cycle level reads 1
// The level follows the synchronized input only after the two have differed
// for DB_CYCLES consecutive cycles; any agreement in between restarts the count.
module btn_debounce #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_2;
        // Only a 0->1 transition of the debounced level is a press.
        press <= sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_credit.sv
// Coin credit stage: debounces three coin buttons and a refund button,
// accumulates a saturating signed balance and serves charge requests.
//   clk, rst     : clock, asynchronous active-low reset
//   coin_btn     : raw coin buttons (credit COIN_A, COIN_B, COIN_C)
//   refund_btn   : raw refund button
//   charge_req   : request level, held high by the requester until charge_ack
//   charge_amt   : unsigned amount, latched when the request is accepted
//   charge_ack   : one-cycle completion pulse
//   charge_ok    : outcome, meaningful only while charge_ack is high
//   bal          : signed balance for the billing stage
//   coin_evt     : one-cycle pulse when any coin is credited
//   refund_evt   : one-cycle pulse when a refund zeroes the balance
// Build option: define COIN_CREDIT_OVERDRAFT_EN to apply every charge and let
// bal go negative down to BAL_MIN; otherwise charges exceeding the available
// balance are refused and bal never drops below 0.
//
// Handshake: a request is accepted in IDLE when charge_req is high; exactly
// two cycles later charge_ack pulses for one cycle with charge_ok. The FSM then
// waits for charge_req to drop before it can accept again, so a level held
// high is serviced once.
module coin_credit
  import credit_pkg::*;
#(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  coin_btn,
  input  logic        refund_btn,
  input  logic        charge_req,
  input  logic [7:0]  charge_amt,
  output logic        charge_ack,
  output logic        charge_ok,
  output logic [11:0] bal,
  output logic        coin_evt,
  output logic        refund_evt
);

  // Bits 2:0 are the coins, bit 3 is refund.
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;

  assign btn_raw = {refund_btn, coin_btn};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_btn (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  // A press pulse only ever accompanies a high debounced level.
  assert property (@(posedge clk) disable iff (!rst) (btn_press & ~btn_level) == 4'b0000);

  chg_state_t state;
  bal_t       bal_q;
  logic [7:0] amt_q;
  logic       refund_pend;

  sum_t credit;
  sum_t amt_ext;
  sum_t avail;
  sum_t base;
  sum_t applied;
  bal_t next_bal;
  logic refund_exec;
  logic refund_hit;
  logic charge_fits;

  assign bal = bal_q;

  always_comb begin
    credit = '0;
    if (btn_press[0]) credit = credit + sum_t'(COIN_A);
    if (btn_press[1]) credit = credit + sum_t'(COIN_B);
    if (btn_press[2]) credit = credit + sum_t'(COIN_C);

    amt_ext = $signed({6'b000000, amt_q});
    avail   = sum_t'(bal_q) + credit;

    // Refunds only run in IDLE, so they never coincide with an EVAL update.
    refund_exec = (state == IDLE) && (btn_press[3] || refund_pend);
    refund_hit  = refund_exec && !bal_q[BAL_W-1] && (bal_q != '0);

`ifdef COIN_CREDIT_OVERDRAFT_EN
    charge_fits = 1'b1;
`else
    charge_fits = (amt_ext <= avail);
`endif

    applied = '0;
    if (state == EVAL && charge_fits) applied = amt_ext;

    // Zero first, then add same-cycle credit, so refund + coin leaves bal = credit.
    base     = refund_hit ? sum_t'(0) : sum_t'(bal_q);
    next_bal = clamp_bal(base + credit - applied);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bal_q       <= '0;
      amt_q       <= '0;
      refund_pend <= 1'b0;
      charge_ack  <= 1'b0;
      charge_ok   <= 1'b0;
      coin_evt    <= 1'b0;
      refund_evt  <= 1'b0;
    end else begin
      bal_q      <= next_bal;
      coin_evt   <= |btn_press[2:0];
      refund_evt <= refund_hit;
      charge_ack <= 1'b0;
      charge_ok  <= 1'b0;

      if (refund_exec) begin
        refund_pend <= 1'b0;
      end else if (btn_press[3]) begin
        refund_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (charge_req) begin
            amt_q <= charge_amt;
            state <= EVAL;
          end
        end
        EVAL: begin
          charge_ack <= 1'b1;
          charge_ok  <= charge_fits;
          state      <= ACK;
        end
        ACK: begin
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!charge_req) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_credit.sv
// Bench for coin_credit with DB_CYCLES = 16. A behavioural model follows the
// credit, refund and charge rules; one process compares every cycle, and
// directed scenarios add hand-computed literal expectations.
module tb_coin_credit;

  localparam int DB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  coin_btn = 3'b000;
  logic        refund_btn = 1'b0;
  logic        charge_req = 1'b0;
  logic [7:0]  charge_amt = 8'd0;
  logic        charge_ack;
  logic        charge_ok;
  logic [11:0] bal;
  logic        coin_evt;
  logic        refund_evt;

  always #5 clk = ~clk;

  coin_credit #(
    .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coin_btn  (coin_btn),
    .refund_btn(refund_btn),
    .charge_req(charge_req),
    .charge_amt(charge_amt),
    .charge_ack(charge_ack),
    .charge_ok (charge_ok),
    .bal       (bal),
    .coin_evt  (coin_evt),
    .refund_evt(refund_evt)
  );

  int checks = 0;
  int errors = 0;
  int coin_cnt = 0;
  int ack_cnt = 0;
  int ref_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_bal;
  bit       m_coin_evt, m_refund_evt, m_ack, m_ok;
  bit [3:0] h1, h2, m_level, m_press;
  int       run [4];
  bit       busy, pend;
  int       since, m_amt;
  int       cr, nx;
  bit       idle_m, ex_m, hit_m, ok_m, eval_m;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_bal = 0; m_coin_evt = 0; m_refund_evt = 0; m_ack = 0; m_ok = 0;
      h1 = 0; h2 = 0; m_level = 0; m_press = 0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      busy = 0; pend = 0; since = 0; m_amt = 0;
    end else begin
      cr = (m_press[0] ? 1 : 0) + (m_press[1] ? 5 : 0) + (m_press[2] ? 10 : 0);
      idle_m = !busy;
      ex_m   = idle_m && (m_press[3] || pend);
      hit_m  = ex_m && (m_bal > 0);
      if (ex_m) pend = 0;
      else if (m_press[3]) pend = 1;

      if (busy) since++;
      eval_m = busy && (since == 1);
`ifdef COIN_CREDIT_OVERDRAFT_EN
      ok_m = 1'b1;
`else
      ok_m = (m_amt <= m_bal + cr);
`endif
      nx = (hit_m ? 0 : m_bal) + cr - ((eval_m && ok_m) ? m_amt : 0);
      if (nx > 2047) nx = 2047;
      if (nx < -2048) nx = -2048;
      m_bal        = nx;
      m_ack        = eval_m;
      m_ok         = eval_m && ok_m;
      m_coin_evt   = (cr > 0);
      m_refund_evt = hit_m;

      if (!idle_m) begin
        if (since >= 3 && !charge_req) busy = 0;
      end else if (charge_req) begin
        busy = 1; since = 0; m_amt = int'(charge_amt);
      end

      // Synchronizer is a 2-cycle delay; level accepts after DB stable cycles.
      m_press = 0;
      for (int i = 0; i < 4; i++) begin
        if (h2[i] != m_level[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            m_level[i] = h2[i];
            run[i]     = 0;
            m_press[i] = h2[i];
          end
        end else begin
          run[i] = 0;
        end
      end
      h2 = h1;
      h1 = {refund_btn, coin_btn};
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_bal", int'(bal), 0);
      check("rst_ack", int'(charge_ack), 0);
      check("rst_ok", int'(charge_ok), 0);
      check("rst_coin_evt", int'(coin_evt), 0);
      check("rst_refund_evt", int'(refund_evt), 0);
    end else begin
      check("bal", int'($signed(bal)), m_bal);
      check("coin_evt", int'(coin_evt), int'(m_coin_evt));
      check("refund_evt", int'(refund_evt), int'(m_refund_evt));
      check("charge_ack", int'(charge_ack), int'(m_ack));
      if (m_ack) check("charge_ok", int'(charge_ok), int'(m_ok));
      if (coin_evt) coin_cnt++;
      if (charge_ack) ack_cnt++;
      if (refund_evt) ref_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_btns(input logic [2:0] coins, input logic refund);
    coin_btn   = coins;
    refund_btn = refund;
    tick(20);
    coin_btn   = 3'b000;
    refund_btn = 1'b0;
    tick(DB + 6);
  endtask

  task automatic do_charge(input int amt, input int hold, output int lat, output int okv);
    charge_amt = amt[7:0];
    charge_req = 1'b1;
    lat = 0;
    while (!charge_ack && lat < 10) begin
      tick(1);
      lat++;
    end
    okv = int'(charge_ok);
    tick(hold);
    charge_req = 1'b0;
    tick(3);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a0, r0, lat, okv;
    tick(3);
    rst = 1'b1;
    tick(2);

    // Bounce immunity: 12 segments of 5 cycles, then a clean 20-cycle hold.
    c0 = coin_cnt;
    for (int i = 0; i < 12; i++) begin
      coin_btn = (i % 2 == 0) ? 3'b010 : 3'b000;
      tick(5);
    end
    press_btns(3'b010, 1'b0);
    check("bounce_evt_cnt", coin_cnt - c0, 1);
    check("bounce_bal", int'($signed(bal)), 5);

    // Simultaneous coins: +16 with a single event.
    c0 = coin_cnt;
    press_btns(3'b111, 1'b0);
    check("simul_evt_cnt", coin_cnt - c0, 1);
    check("simul_bal", int'($signed(bal)), 21);

    // Refund from a positive balance.
    r0 = ref_cnt;
    press_btns(3'b000, 1'b1);
    check("refund_evt_cnt", ref_cnt - r0, 1);
    check("refund_bal", int'($signed(bal)), 0);

    press_btns(3'b100, 1'b0);
    press_btns(3'b100, 1'b0);
    check("bal_20", int'($signed(bal)), 20);

    // Accepted charge, request held 10 extra cycles.
    a0 = ack_cnt;
    do_charge(12, 10, lat, okv);
    check("chg12_latency", lat, 2);
    check("chg12_ok", okv, 1);
    check("chg12_bal", int'($signed(bal)), 8);
    check("chg12_ack_cnt", ack_cnt - a0, 1);

`ifdef COIN_CREDIT_OVERDRAFT_EN
    do_charge(200, 0, lat, okv);
    check("ovd200_ok", okv, 1);
    check("ovd200_bal", int'($signed(bal)), -192);
    check("ovd200_bits", int'(bal), 'hF40);
    for (int i = 0; i < 8; i++) do_charge(255, 0, lat, okv);
    check("ovd_clamp_bal", int'($signed(bal)), -2048);
    r0 = ref_cnt;
    press_btns(3'b000, 1'b1);
    check("ovd_refund_ignored", ref_cnt - r0, 0);
    check("ovd_refund_bal", int'($signed(bal)), -2048);
`else
    do_charge(9, 0, lat, okv);
    check("chg9_latency", lat, 2);
    check("chg9_refused", okv, 0);
    check("chg9_bal", int'($signed(bal)), 8);
    do_charge(8, 0, lat, okv);
    check("chg8_ok", okv, 1);
    check("chg8_bal", int'($signed(bal)), 0);
    r0 = ref_cnt;
    press_btns(3'b000, 1'b1);
    check("zero_refund_ignored", ref_cnt - r0, 0);
    check("zero_refund_bal", int'($signed(bal)), 0);
`endif

    // Saturation at BAL_MAX: 128 x 16 = 2048 clamps to 2047.
    pulse_reset();
    for (int i = 0; i < 128; i++) press_btns(3'b111, 1'b0);
    check("sat_bal", int'($signed(bal)), 2047);
    c0 = coin_cnt;
    press_btns(3'b001, 1'b0);
    check("sat_evt_cnt", coin_cnt - c0, 1);
    check("sat_bal_held", int'($signed(bal)), 2047);

    // Refund press landing while the charge FSM is busy.
    pulse_reset();
    for (int i = 0; i < 3; i++) press_btns(3'b100, 1'b0);
    check("bal_30", int'($signed(bal)), 30);
    r0 = ref_cnt;
    refund_btn = 1'b1;
    tick(16);
    do_charge(5, 0, lat, okv);
    refund_btn = 1'b0;
    tick(DB + 6);
    check("busy_refund_latency", lat, 2);
    check("busy_refund_ok", okv, 1);
    check("busy_refund_evt_cnt", ref_cnt - r0, 1);
    check("busy_refund_bal", int'($signed(bal)), 0);

    // Reset in the middle of a debounce: no credit afterwards.
    press_btns(3'b001, 1'b0);
    check("bal_1", int'($signed(bal)), 1);
    coin_btn = 3'b100;
    tick(10);
    rst = 1'b0;
    tick(2);
    coin_btn = 3'b000;
    tick(1);
    rst = 1'b1;
    c0 = coin_cnt;
    tick(40);
    check("mid_reset_no_evt", coin_cnt - c0, 0);
    check("mid_reset_bal", int'($signed(bal)), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
